// File: rtl/dj8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dj8_pkg
// Description : Shared DJ8 definitions: ALU opcodes, shifter selects,
//               MUL/DIV mode encoding and the MUL/DIV sequencer state type.
// Revision    : 1.0 - initial release
// ============================================================================
package dj8_pkg;

    // ALU opcodes
    localparam logic [2:0] c_ALU_ADD  = 3'h0;
    localparam logic [2:0] c_ALU_ADDC = 3'h1;
    localparam logic [2:0] c_ALU_SUBC = 3'h2;
    localparam logic [2:0] c_ALU_MOVR = 3'h3;
    localparam logic [2:0] c_ALU_XOR  = 3'h4;
    localparam logic [2:0] c_ALU_OR   = 3'h5;
    localparam logic [2:0] c_ALU_AND  = 3'h6;
    localparam logic [2:0] c_ALU_MOVI = 3'h7;

    // Post-ALU shifter selects
    localparam logic [1:0] c_SH_NONE = 2'b00;
    localparam logic [1:0] c_SH_SHR  = 2'b01;
    localparam logic [1:0] c_SH_SAR  = 2'b10;

    // MUL/DIV unit mode
    localparam logic c_MODE_MUL = 1'b0;
    localparam logic c_MODE_DIV = 1'b1;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : 8-bit DJ8 ALU, purely combinational.
//               i_a, i_b   : operands
//               i_opalu    : opcode (see dj8_pkg)
//               i_c_in     : carry/borrow in (ADDC, SUBC)
//               i_shift    : post-op shift (none / logical right / arith right)
//               o_result   : shifted result
//               o_c_out    : carry out (ADD/ADDC) or borrow out (SUBC)
//               o_zero     : result == 0
// Revision    : 1.0 - initial release
// ============================================================================
module alu
    import dj8_pkg::*;
(
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic [2:0] i_opalu,
    input  logic       i_c_in,
    input  logic [1:0] i_shift,
    output logic [7:0] o_result,
    output logic       o_c_out,
    output logic       o_zero
);

    logic [8:0] w_raw;

    always_comb begin
        w_raw = '0;
        case (i_opalu)
            c_ALU_ADD:  w_raw = {1'b0, i_a} + {1'b0, i_b};
            c_ALU_ADDC: w_raw = {1'b0, i_a} + {1'b0, i_b} + {8'b0, i_c_in};
            // Bit 8 of the 9-bit difference is the borrow out.
            c_ALU_SUBC: w_raw = {1'b0, i_a} - {1'b0, i_b} - {8'b0, i_c_in};
            c_ALU_MOVR: w_raw = {1'b0, i_a};
            c_ALU_XOR:  w_raw = {1'b0, i_a ^ i_b};
            c_ALU_OR:   w_raw = {1'b0, i_a | i_b};
            c_ALU_AND:  w_raw = {1'b0, i_a & i_b};
            c_ALU_MOVI: w_raw = {1'b0, i_b};
            default:    w_raw = '0;
        endcase

        case (i_shift)
            c_SH_SHR: o_result = {1'b0, w_raw[7:1]};
            c_SH_SAR: o_result = {w_raw[7], w_raw[7:1]};
            default:  o_result = w_raw[7:0];
        endcase

        o_c_out = w_raw[8];
        o_zero  = (o_result == 8'h00);
    end

endmodule
`default_nettype wire

// File: rtl/dj8_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : dj8_muldiv_seq
// Description : Multi-cycle unsigned 8x8 multiply (shift-and-add) and 8/8
//               divide (restoring) unit built around one DJ8 ALU instance.
//               clk, rst        : clock, synchronous active-high reset
//               start, mode     : request (sampled in IDLE/DONE), 0=MUL 1=DIV
//               op_a, op_b      : multiplicand/dividend, multiplier/divisor
//               busy, done      : iterating, one-cycle completion pulse
//               res_hi, res_lo  : MUL product hi/lo, DIV remainder/quotient
//               dz              : last operation was a divide by zero
// Revision    : 1.0 - initial release
// ============================================================================
module dj8_muldiv_seq
    import dj8_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mode,
    input  logic [7:0] op_a,
    input  logic [7:0] op_b,
    output logic       busy,
    output logic       done,
    output logic [7:0] res_hi,
    output logic [7:0] res_lo,
    output logic       dz
);

    seq_state_t r_state, w_state_nxt;
    logic [2:0] r_cnt,   w_cnt_nxt;
    logic [7:0] r_hi,    w_hi_nxt;     // MUL: product high / DIV: remainder
    logic [7:0] r_lo,    w_lo_nxt;     // MUL: multiplier/product low / DIV: quotient
    logic [7:0] r_opb,   w_opb_nxt;    // multiplicand (MUL) or divisor (DIV)
    logic       r_mode,  w_mode_nxt;
    logic       r_dz,    w_dz_nxt;

    logic [7:0] w_alu_a;
    logic [7:0] w_alu_b;
    logic [2:0] w_alu_op;
    logic [7:0] w_alu_res;
    logic       w_alu_cout;
    logic       w_alu_zero_unused;
    logic [7:0] w_div_s;
    logic       w_div_ok;

    // ALU operand steering, driven only from registers.
    always_comb begin
        w_div_s = {r_hi[6:0], r_lo[7]};
        if (r_mode == c_MODE_DIV) begin
            w_alu_a  = w_div_s;
            w_alu_op = c_ALU_SUBC;
        end else begin
            w_alu_a  = r_hi;
            // MOVR passes hi through with carry 0 when the multiplier bit is 0.
            w_alu_op = r_lo[0] ? c_ALU_ADD : c_ALU_MOVR;
        end
        w_alu_b = r_opb;
    end

    alu u_alu (
        .i_a      (w_alu_a),
        .i_b      (w_alu_b),
        .i_opalu  (w_alu_op),
        .i_c_in   (1'b0),
        .i_shift  (c_SH_NONE),
        .o_result (w_alu_res),
        .o_c_out  (w_alu_cout),
        .o_zero   (w_alu_zero_unused)
    );

    // A shifted-out remainder MSB means the 9-bit partial remainder already
    // exceeds any 8-bit divisor, so the subtraction succeeds regardless of
    // the borrow, and the 8-bit difference is still exact.
    assign w_div_ok = r_hi[7] | ~w_alu_cout;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_opb_nxt   = r_opb;
        w_mode_nxt  = r_mode;
        w_dz_nxt    = r_dz;
        busy        = 1'b0;
        done        = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                done = (r_state == ST_DONE);
                if (start) begin
                    w_mode_nxt = mode;
                    w_opb_nxt  = op_b;
                    w_cnt_nxt  = 3'd0;
                    if ((mode == c_MODE_DIV) && (op_b == 8'h00)) begin
                        w_state_nxt = ST_DONE;
                        w_hi_nxt    = op_a;
                        w_lo_nxt    = 8'hFF;
                        w_dz_nxt    = 1'b1;
                    end else begin
                        w_state_nxt = ST_RUN;
                        w_hi_nxt    = 8'h00;
                        w_lo_nxt    = op_a;
                        w_dz_nxt    = 1'b0;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_RUN: begin
                busy      = 1'b1;
                w_cnt_nxt = r_cnt + 3'd1;
                if (r_mode == c_MODE_DIV) begin
                    w_hi_nxt = w_div_ok ? w_alu_res : w_div_s;
                    w_lo_nxt = {r_lo[6:0], w_div_ok};
                end else begin
                    w_hi_nxt = {w_alu_cout, w_alu_res[7:1]};
                    w_lo_nxt = {w_alu_res[0], r_lo[7:1]};
                end
                if (r_cnt == 3'd7) begin
                    w_state_nxt = ST_DONE;
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
            r_hi    <= 8'h00;
            r_lo    <= 8'h00;
            r_opb   <= 8'h00;
            r_mode  <= c_MODE_MUL;
            r_dz    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_opb   <= w_opb_nxt;
            r_mode  <= w_mode_nxt;
            r_dz    <= w_dz_nxt;
        end
    end

    assign res_hi = r_hi;
    assign res_lo = r_lo;
    assign dz     = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_dj8_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_dj8_muldiv_seq
// Description : Self-checking bench for dj8_muldiv_seq. Expected results come
//               from plain integer multiply/divide/modulo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dj8_muldiv_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] op_a = 8'h00;
    logic [7:0] op_b = 8'h00;
    logic       busy;
    logic       done;
    logic [7:0] res_hi;
    logic [7:0] res_lo;
    logic       dz;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    dj8_muldiv_seq dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .res_hi (res_hi),
        .res_lo (res_lo),
        .dz     (dz)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issues one operation at the current negedge and follows it to DONE.
    // hold  : leave start high afterwards (back-to-back acceptance)
    // glitch: pulse start at RUN cycles 3 and 5 with junk operands
    task automatic run_op(input logic md, input logic [7:0] a, input logic [7:0] b,
                          input bit hold, input bit glitch);
        int ia, ib, p;
        logic [7:0] e_hi, e_lo;
        logic       e_dz;
        ia = int'(a);
        ib = int'(b);
        if (md == 1'b0) begin
            p    = ia * ib;
            e_hi = 8'(p >> 8);
            e_lo = 8'(p);
            e_dz = 1'b0;
        end else if (ib == 0) begin
            e_hi = a;
            e_lo = 8'hFF;
            e_dz = 1'b1;
        end else begin
            e_hi = 8'(ia % ib);
            e_lo = 8'(ia / ib);
            e_dz = 1'b0;
        end

        start = 1'b1;
        mode  = md;
        op_a  = a;
        op_b  = b;
        @(negedge clk);
        if (!hold) start = 1'b0;

        if (!(md == 1'b1 && ib == 0)) begin
            for (int i = 1; i <= 8; i++) begin
                chk("busy_run", {15'b0, busy}, 16'd1);
                chk("done_early", {15'b0, done}, 16'd0);
                // Operand and mode changes while iterating must be ignored.
                op_a = 8'($urandom);
                op_b = 8'($urandom);
                mode = 1'($urandom);
                if (glitch) start = (i == 3 || i == 5);
                @(negedge clk);
            end
            if (glitch) start = 1'b0;
        end

        chk("done", {15'b0, done}, 16'd1);
        chk("busy_done", {15'b0, busy}, 16'd0);
        chk("result", {res_hi, res_lo}, {e_hi, e_lo});
        chk("dz", {15'b0, dz}, {15'b0, e_dz});
    endtask

    initial begin : stim
        logic       r_md;
        logic [7:0] r_a, r_b;
        bit         hold, last_hold;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", {15'b0, busy}, 16'd0);
        chk("rst_done", {15'b0, done}, 16'd0);
        chk("rst_res", {res_hi, res_lo}, 16'h0000);
        chk("rst_dz", {15'b0, dz}, 16'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed multiplies and divides
        run_op(1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0);
        @(negedge clk);
        chk("hold_res", {res_hi, res_lo}, 16'hFE01);
        chk("idle_done", {15'b0, done}, 16'd0);
        run_op(1'b0, 8'd13, 8'd11, 1'b0, 1'b0);
        run_op(1'b0, 8'h00, 8'hA5, 1'b0, 1'b0);
        run_op(1'b0, 8'h80, 8'h02, 1'b0, 1'b0);
        run_op(1'b1, 8'd200, 8'd7, 1'b0, 1'b0);
        run_op(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0);
        run_op(1'b1, 8'hFF, 8'h80, 1'b0, 1'b0);
        @(negedge clk);

        // Divide by zero then a multiply clearing dz
        run_op(1'b1, 8'h5A, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        run_op(1'b0, 8'd2, 8'd3, 1'b0, 1'b0);

        // start held high: back-to-back with alternating operands
        run_op(1'b0, 8'h12, 8'h34, 1'b1, 1'b0);
        run_op(1'b1, 8'hF0, 8'h0F, 1'b1, 1'b0);
        run_op(1'b0, 8'h34, 8'h12, 1'b1, 1'b0);
        run_op(1'b1, 8'h0F, 8'h03, 1'b0, 1'b0);
        @(negedge clk);

        // start pulses during RUN have no effect
        run_op(1'b1, 8'd250, 8'd9, 1'b0, 1'b1);
        @(negedge clk);

        // Reset at RUN cycle 4 aborts the operation
        start = 1'b1; mode = 1'b0; op_a = 8'hC3; op_b = 8'h5D;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {15'b0, busy}, 16'd0);
        chk("abort_done", {15'b0, done}, 16'd0);
        chk("abort_res", {res_hi, res_lo}, 16'h0000);
        chk("abort_dz", {15'b0, dz}, 16'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("abort_no_done", {15'b0, done}, 16'd0);
        end
        run_op(1'b0, 8'd7, 8'd9, 1'b0, 1'b0);
        @(negedge clk);

        // Randomized operations against the arithmetic model
        last_hold = 1'b0;
        for (int n = 0; n < 60; n++) begin
            r_md = 1'($urandom);
            r_a  = 8'($urandom);
            r_b  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            hold = ($urandom_range(0, 2) == 0);
            if (!last_hold) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    chk("rand_idle_done", {15'b0, done}, 16'd0);
                end
            end
            run_op(r_md, r_a, r_b, hold, ($urandom_range(0, 3) == 0));
            last_hold = hold;
        end
        start = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
